// File: rtl/note_pkg.sv
// Shared definitions for the note-to-phase converter: FSM states, octave
// constants and the top-octave phase-increment table (48 kHz, 32-bit accumulator).
package note_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DIV   = 2'd1,
        ST_SHIFT = 2'd2,
        ST_OUT   = 2'd3
    } state_t;

    localparam int NOTES_PER_OCT = 12;
    localparam int TOP_OCT       = 10;

    // Increments for MIDI notes 120..131; lower octaves are right shifts of these.
    localparam logic [31:0] PHASE_TABLE [0:11] = '{
        32'd749115498,  32'd793660223,  32'd840853716,  32'd890853480,
        32'd943826385,  32'd999949222,  32'd1059409297, 32'd1122405052,
        32'd1189146729, 32'd1259857073, 32'd1334772074, 32'd1414141751
    };

    // Adds a signed detune to an unsigned increment, clamping to the 32-bit range.
    function automatic logic [31:0] add_detune(input logic [31:0] inc, input logic [7:0] detune);
        logic signed [33:0] sum;
        sum = $signed({2'b00, inc}) + $signed({{26{detune[7]}}, detune});
        if (sum < 34'sd0) begin
            return 32'd0;
        end else if (sum > 34'sd4294967295) begin
            return 32'hFFFF_FFFF;
        end else begin
            return sum[31:0];
        end
    endfunction

endpackage

// File: rtl/note_div12.sv
// Iterative divide-by-12: splits a MIDI note into octave and note-in-octave,
// subtracting one octave per enabled cycle after start loads the note.
module note_div12
    import note_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       en,
    input  logic [6:0] note,
    output logic [3:0] rem,
    output logic [3:0] oct,
    output logic       done
);

    logic [6:0] rem_r;
    logic [3:0] oct_r;
    logic       step_s;

    // One subtraction step per cycle while enabled and a full octave remains.
    always_comb begin
        step_s = 1'b0;
        if (en && (rem_r >= 7'(NOTES_PER_OCT))) begin
            step_s = 1'b1;
        end else begin
            step_s = 1'b0;
        end
    end

    // Remainder / octave counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_r <= 7'd0;
            oct_r <= 4'd0;
        end else if (start) begin
            rem_r <= note;
            oct_r <= 4'd0;
        end else if (step_s) begin
            rem_r <= rem_r - 7'(NOTES_PER_OCT);
            oct_r <= oct_r + 4'd1;
        end
    end

    assign done = (rem_r < 7'(NOTES_PER_OCT));
    assign rem  = rem_r[3:0];
    assign oct  = oct_r;

endmodule

// File: rtl/note_to_phase.sv
// Converts a per-voice note config word into an oscillator phase increment.
// Optional detune (cfg_data[23:16]) is compiled in with NOTE_TO_PHASE_DETUNE_EN.
module note_to_phase
    import note_pkg::*;
#(
    parameter int VOICE_W = 2,
    parameter int PHASE_W = 32
) (
    input  logic               ACLK,
    input  logic               ARESETN,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [VOICE_W-1:0] cfg_voice,
    input  logic [31:0]        cfg_data,
    output logic               phase_valid,
    input  logic               phase_ready,
    output logic [VOICE_W-1:0] phase_voice,
    output logic [PHASE_W-1:0] phase_inc,
    output logic               phase_gate,
    output logic               busy
);

    state_t              state_r;
    state_t              next_state_s;
    logic                accept_s;
    logic                div_done_s;
    logic [3:0]          div_rem_s;
    logic [3:0]          div_oct_s;
    logic [3:0]          shamt_s;
    logic [31:0]         base_s;
    logic [31:0]         inc_s;
    logic                cfg_ready_r;
    logic                busy_r;
    logic                phase_valid_r;
    logic [PHASE_W-1:0]  phase_inc_r;
    logic [VOICE_W-1:0]  voice_r;
    logic                gate_r;
    logic                unused_s;

`ifdef NOTE_TO_PHASE_DETUNE_EN
    logic [7:0]          detune_r;
    assign unused_s = ^{cfg_data[31:24], cfg_data[15:9], cfg_data[7]};
`else
    assign unused_s = ^{cfg_data[31:9], cfg_data[7]};
`endif

    assign accept_s = cfg_valid && cfg_ready_r;

    note_div12 u_div (
        .clk   (ACLK),
        .rst_n (ARESETN),
        .start (accept_s),
        .en    (state_r == ST_DIV),
        .note  (cfg_data[6:0]),
        .rem   (div_rem_s),
        .oct   (div_oct_s),
        .done  (div_done_s)
    );

    // Next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE:  if (accept_s) next_state_s = ST_DIV;    else next_state_s = ST_IDLE;
            ST_DIV:   if (div_done_s) next_state_s = ST_SHIFT; else next_state_s = ST_DIV;
            ST_SHIFT: next_state_s = ST_OUT;
            ST_OUT:   if (phase_ready) next_state_s = ST_IDLE; else next_state_s = ST_OUT;
            default:  next_state_s = ST_IDLE;
        endcase
    end

    // Octave scaling of the top-octave table entry, plus optional detune.
    always_comb begin
        shamt_s = 4'(TOP_OCT) - div_oct_s;
        if (div_rem_s < 4'(NOTES_PER_OCT)) begin
            base_s = PHASE_TABLE[div_rem_s];
        end else begin
            base_s = 32'd0;
        end
`ifdef NOTE_TO_PHASE_DETUNE_EN
        inc_s = add_detune(base_s >> shamt_s, detune_r);
`else
        inc_s = base_s >> shamt_s;
`endif
    end

    // State register.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Registered handshake flags, latched word fields and result.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            cfg_ready_r   <= 1'b0;
            busy_r        <= 1'b0;
            phase_valid_r <= 1'b0;
            phase_inc_r   <= '0;
            voice_r       <= '0;
            gate_r        <= 1'b0;
`ifdef NOTE_TO_PHASE_DETUNE_EN
            detune_r      <= 8'd0;
`endif
        end else begin
            cfg_ready_r <= (next_state_s == ST_IDLE);
            busy_r      <= (next_state_s != ST_IDLE);
            if (accept_s) begin
                voice_r  <= cfg_voice;
                gate_r   <= cfg_data[8];
`ifdef NOTE_TO_PHASE_DETUNE_EN
                detune_r <= cfg_data[23:16];
`endif
            end
            if (state_r == ST_SHIFT) begin
                phase_inc_r   <= inc_s[31 -: PHASE_W];
                phase_valid_r <= 1'b1;
            end else if (phase_valid_r && phase_ready) begin
                phase_valid_r <= 1'b0;
            end
        end
    end

    assign cfg_ready   = cfg_ready_r;
    assign busy        = busy_r;
    assign phase_valid = phase_valid_r;
    assign phase_inc   = phase_inc_r;
    assign phase_voice = voice_r;
    assign phase_gate  = gate_r;

endmodule

// File: tb/tb_note_to_phase.sv
// Self-checking bench for note_to_phase; the reference recomputes the pitch
// formula in real arithmetic. Honours NOTE_TO_PHASE_DETUNE_EN when defined.
module tb_note_to_phase;

    localparam int VOICE_W = 2;
    localparam int PHASE_W = 32;
`ifdef NOTE_TO_PHASE_DETUNE_EN
    localparam bit DETUNE_EN = 1'b1;
`else
    localparam bit DETUNE_EN = 1'b0;
`endif

    logic               ACLK = 1'b0;
    logic               ARESETN = 1'b0;
    logic               cfg_valid = 1'b0;
    logic               cfg_ready;
    logic [VOICE_W-1:0] cfg_voice = '0;
    logic [31:0]        cfg_data = '0;
    logic               phase_valid;
    logic               phase_ready = 1'b0;
    logic [VOICE_W-1:0] phase_voice;
    logic [PHASE_W-1:0] phase_inc;
    logic               phase_gate;
    logic               busy;

    int checks = 0;
    int failures = 0;

    always #5 ACLK = ~ACLK;

    note_to_phase #(.VOICE_W(VOICE_W), .PHASE_W(PHASE_W)) dut (
        .ACLK        (ACLK),
        .ARESETN     (ARESETN),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_voice   (cfg_voice),
        .cfg_data    (cfg_data),
        .phase_valid (phase_valid),
        .phase_ready (phase_ready),
        .phase_voice (phase_voice),
        .phase_inc   (phase_inc),
        .phase_gate  (phase_gate),
        .busy        (busy)
    );

    // Equal-tempered frequency of MIDI note n, expressed as a 32-bit increment at 48 kHz.
    function automatic longint ref_note_inc(input int n);
        real f;
        f = 440.0 * (2.0 ** ((real'(n) - 69.0) / 12.0));
        return longint'($floor(f * 4294967296.0 / 48000.0 + 0.5));
    endfunction

    function automatic logic [PHASE_W-1:0] ref_inc(input int note, input int detune);
        longint v;
        v = ref_note_inc(120 + note % 12) >> (10 - note / 12);
        if (DETUNE_EN) begin
            v = v + detune;
            if (v < 0) v = 0;
            if (v > 64'sd4294967295) v = 64'sd4294967295;
        end
        v = v >> (32 - PHASE_W);
        return v[PHASE_W-1:0];
    endfunction

    task automatic send_word(input int note, input bit gate, input int voice, input int detune);
        int guard;
        guard = 0;
        while (cfg_ready !== 1'b1 && guard < 50) begin
            @(posedge ACLK); #1;
            guard++;
        end
        cfg_data        = $urandom;
        cfg_data[6:0]   = 7'(note);
        cfg_data[8]     = gate;
        cfg_data[23:16] = 8'(detune);
        cfg_voice       = VOICE_W'(voice);
        cfg_valid       = 1'b1;
        @(posedge ACLK); #1;
        cfg_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (phase_valid !== 1'b1 && lat < 40) begin
            @(posedge ACLK); #1;
            lat++;
        end
    endtask

    task automatic handshake();
        phase_ready = 1'b1;
        @(posedge ACLK); #1;
        phase_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge ACLK);
        #3;
        checks++;
        if ({cfg_ready, phase_valid, phase_inc, phase_voice, phase_gate, busy} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got rdy=%b vld=%b inc=%0d voice=%0d gate=%b busy=%b, want all 0",
                     cfg_ready, phase_valid, phase_inc, phase_voice, phase_gate, busy);
        end
        ARESETN = 1'b1;
        @(posedge ACLK); #1;
        checks++;
        if (cfg_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_release: got cfg_ready=%b busy=%b, want 1 0", cfg_ready, busy);
        end
    endtask

    task automatic test_directed();
        int notes [4] = '{120, 0, 69, 127};
        bit gates [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        int voices [4] = '{2, 1, 0, 3};
        int lat;
        for (int i = 0; i < 4; i++) begin
            send_word(notes[i], gates[i], voices[i], 0);
            checks++;
            if (busy !== 1'b1 || cfg_ready !== 1'b0) begin
                failures++;
                $display("FAIL dir_busy note=%0d: got busy=%b cfg_ready=%b, want 1 0", notes[i], busy, cfg_ready);
            end
            wait_valid(lat);
            checks++;
            if (lat !== notes[i] / 12 + 2) begin
                failures++;
                $display("FAIL dir_latency note=%0d: got %0d, want %0d", notes[i], lat, notes[i] / 12 + 2);
            end
            checks++;
            if (phase_inc !== ref_inc(notes[i], 0)) begin
                failures++;
                $display("FAIL dir_inc note=%0d: got %0d, want %0d", notes[i], phase_inc, ref_inc(notes[i], 0));
            end
            checks++;
            if (phase_gate !== gates[i] || phase_voice !== VOICE_W'(voices[i])) begin
                failures++;
                $display("FAIL dir_gate_voice note=%0d: got gate=%b voice=%0d, want %b %0d",
                         notes[i], phase_gate, phase_voice, gates[i], voices[i]);
            end
            handshake();
            checks++;
            if (cfg_ready !== 1'b1 || phase_valid !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL dir_return note=%0d: got rdy=%b vld=%b busy=%b, want 1 0 0",
                         notes[i], cfg_ready, phase_valid, busy);
            end
        end
    endtask

    task automatic test_random();
        int note, voice, detune, lat;
        bit gate;
        for (int i = 0; i < 24; i++) begin
            note   = $urandom_range(0, 127);
            voice  = $urandom_range(0, 3);
            gate   = 1'($urandom_range(0, 1));
            detune = int'($urandom_range(0, 255)) - 128;
            send_word(note, gate, voice, detune);
            wait_valid(lat);
            checks++;
            if (lat !== note / 12 + 2 || phase_inc !== ref_inc(note, detune)
                || phase_gate !== gate || phase_voice !== VOICE_W'(voice)) begin
                failures++;
                $display("FAIL rand note=%0d det=%0d: got lat=%0d inc=%0d gate=%b voice=%0d, want %0d %0d %b %0d",
                         note, detune, lat, phase_inc, phase_gate, phase_voice,
                         note / 12 + 2, ref_inc(note, detune), gate, voice);
            end
            repeat ($urandom_range(0, 3)) begin
                @(posedge ACLK); #1;
            end
            handshake();
        end
    endtask

    task automatic test_backpressure();
        int lat;
        logic [PHASE_W-1:0] exp_inc;
        exp_inc = ref_inc(50, 0);
        send_word(50, 1'b1, 3, 0);
        wait_valid(lat);
        for (int c = 0; c < 20; c++) begin
            checks++;
            if (phase_valid !== 1'b1 || phase_inc !== exp_inc || phase_voice !== 2'd3
                || phase_gate !== 1'b1 || cfg_ready !== 1'b0) begin
                failures++;
                $display("FAIL stall cycle=%0d: got vld=%b inc=%0d voice=%0d gate=%b rdy=%b, want 1 %0d 3 1 0",
                         c, phase_valid, phase_inc, phase_voice, phase_gate, cfg_ready, exp_inc);
            end
            @(posedge ACLK); #1;
        end
        handshake();
        checks++;
        if (cfg_ready !== 1'b1 || phase_valid !== 1'b0) begin
            failures++;
            $display("FAIL stall_release: got rdy=%b vld=%b, want 1 0", cfg_ready, phase_valid);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        send_word(30, 1'b0, 1, 0);
        cfg_data        = 32'd0;
        cfg_data[6:0]   = 7'd5;
        cfg_data[8]     = 1'b1;
        cfg_voice       = 2'd2;
        cfg_valid       = 1'b1;
        wait_valid(lat);
        checks++;
        if (lat !== 4 || phase_inc !== ref_inc(30, 0) || phase_voice !== 2'd1 || phase_gate !== 1'b0) begin
            failures++;
            $display("FAIL b2b_first: got lat=%0d inc=%0d voice=%0d gate=%b, want 4 %0d 1 0",
                     lat, phase_inc, phase_voice, phase_gate, ref_inc(30, 0));
        end
        handshake();
        checks++;
        if (cfg_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL b2b_idle: got rdy=%b busy=%b, want 1 0", cfg_ready, busy);
        end
        @(posedge ACLK); #1;
        cfg_valid = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL b2b_accept: got busy=%b, want 1", busy);
        end
        wait_valid(lat);
        checks++;
        if (lat !== 2 || phase_inc !== ref_inc(5, 0) || phase_voice !== 2'd2 || phase_gate !== 1'b1) begin
            failures++;
            $display("FAIL b2b_second: got lat=%0d inc=%0d voice=%0d gate=%b, want 2 %0d 2 1",
                     lat, phase_inc, phase_voice, phase_gate, ref_inc(5, 0));
        end
        handshake();
    endtask

    task automatic test_reset_mid();
        int lat;
        int stray;
        send_word(100, 1'b1, 3, 0);
        repeat (3) begin
            @(posedge ACLK); #1;
        end
        #2;
        ARESETN = 1'b0;
        #1;
        checks++;
        if ({cfg_ready, phase_valid, phase_inc, phase_voice, phase_gate, busy} !== '0) begin
            failures++;
            $display("FAIL midreset_outputs: got rdy=%b vld=%b inc=%0d voice=%0d gate=%b busy=%b, want all 0",
                     cfg_ready, phase_valid, phase_inc, phase_voice, phase_gate, busy);
        end
        #10;
        ARESETN = 1'b1;
        stray = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge ACLK); #1;
            if (phase_valid !== 1'b0 || busy !== 1'b0) stray++;
        end
        checks++;
        if (stray !== 0 || cfg_ready !== 1'b1) begin
            failures++;
            $display("FAIL midreset_discard: got %0d cycles with valid/busy, rdy=%b, want 0 and 1", stray, cfg_ready);
        end
        send_word(12, 1'b0, 0, 0);
        wait_valid(lat);
        checks++;
        if (lat !== 3 || phase_inc !== ref_inc(12, 0)) begin
            failures++;
            $display("FAIL midreset_next: got lat=%0d inc=%0d, want 3 %0d", lat, phase_inc, ref_inc(12, 0));
        end
        handshake();
    endtask

    task automatic test_detune();
        int notes [2] = '{0, 127};
        int dets [2] = '{-128, 127};
        int lat;
        for (int i = 0; i < 2; i++) begin
            send_word(notes[i], 1'b1, 0, dets[i]);
            wait_valid(lat);
            checks++;
            if (lat !== notes[i] / 12 + 2 || phase_inc !== ref_inc(notes[i], dets[i])) begin
                failures++;
                $display("FAIL detune note=%0d det=%0d: got lat=%0d inc=%0d, want %0d %0d",
                         notes[i], dets[i], lat, phase_inc, notes[i] / 12 + 2, ref_inc(notes[i], dets[i]));
            end
            handshake();
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_detune();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule
